// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and FSM state types for the memory responder.
//   burst_e  : AxBURST encodings (FIXED, INCR, WRAP, reserved)
//   resp_e   : xRESP encodings (OKAY, EXOKAY, SLVERR, DECERR)
//   w_state_e: write-channel FSM states
//   r_state_e: read-channel FSM states
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/byte_enable_memory.sv
// DEPTH x DATA_WIDTH storage with one byte-strobed write port and one
// registered read port. A read and a write to the same word in the same
// cycle return the old contents (read-before-write).
//   clk   : clock
//   we    : write enable; wstrb selects the byte lanes written at waddr
//   re    : read enable; rdata is updated on the next clock edge from raddr
//   rdata : registered read data, holds while re is low
module byte_enable_memory #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 256,
  parameter int ADDR_BITS  = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_BITS-1:0]    waddr,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    re,
  input  logic [ADDR_BITS-1:0]    raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int BYTES = DATA_WIDTH / 8;

  // One independent array per byte lane keeps each lane a plain
  // single-write-port RAM with no partial-word update logic.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] lane_q;

    always_ff @(posedge clk) begin
      if (we && wstrb[gi]) begin
        lane_mem[waddr] <= wdata[gi*8 +: 8];
      end
      if (re) begin
        lane_q <= lane_mem[raddr];
      end
    end

    assign rdata[gi*8 +: 8] = lane_q;
  end

endmodule

// File: rtl/axi_memory_responder.sv
// AXI4 subordinate backed by a byte-strobed memory. Services one write burst
// and one read burst at a time, independently of each other.
//   data_aclk/data_aresetn : clock, synchronous active-low reset
//   data_aw* / data_w* / data_b* : write address, data and response channels
//   data_ar* / data_r*           : read address and data channels
// Supported: FIXED and INCR bursts at full bus width. Anything else is
// consumed and answered with SLVERR; beats outside the memory get DECERR.
module axi_memory_responder
  import axi_pkg::*;
#(
  parameter int                    ID_WIDTH     = 24,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 256,
  parameter int                    DEPTH        = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = '0
) (
  input  logic                    data_aclk,
  input  logic                    data_aresetn,
  input  logic [ID_WIDTH-1:0]     data_awid,
  input  logic [ADDR_WIDTH-1:0]   data_awaddr,
  input  logic [7:0]              data_awlen,
  input  logic [2:0]              data_awsize,
  input  logic [1:0]              data_awburst,
  input  logic [2:0]              data_awprot,
  input  logic [3:0]              data_awqos,
  input  logic                    data_awvalid,
  output logic                    data_awready,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_wstrb,
  input  logic                    data_wlast,
  input  logic                    data_wvalid,
  output logic                    data_wready,
  output logic [ID_WIDTH-1:0]     data_bid,
  output logic [1:0]              data_bresp,
  output logic                    data_bvalid,
  input  logic                    data_bready,
  input  logic [ID_WIDTH-1:0]     data_arid,
  input  logic [ADDR_WIDTH-1:0]   data_araddr,
  input  logic [7:0]              data_arlen,
  input  logic [2:0]              data_arsize,
  input  logic [1:0]              data_arburst,
  input  logic [2:0]              data_arprot,
  input  logic [3:0]              data_arqos,
  input  logic                    data_arvalid,
  output logic                    data_arready,
  output logic [ID_WIDTH-1:0]     data_rid,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic [1:0]              data_rresp,
  output logic                    data_rlast,
  output logic                    data_rvalid,
  input  logic                    data_rready
);

  localparam int                    STRB_WIDTH = DATA_WIDTH / 8;
  localparam int                    SIZE_LOG2  = $clog2(STRB_WIDTH);
  localparam int                    MEM_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(BEAT_BYTES - 1'b1);

  // Protection and QoS carry no meaning for a plain memory.
  logic unused_sideband;
  assign unused_sideband = ^{data_awprot, data_awqos, data_arprot, data_arqos};

  function automatic logic supported(input logic [1:0] burst, input logic [2:0] size);
    return ((burst == BURST_FIXED) || (burst == BURST_INCR)) && (size == 3'(SIZE_LOG2));
  endfunction

  // ovf marks an address that has already wrapped past the top of the
  // address space during an INCR burst.
  function automatic logic beat_in_range(input logic [ADDR_WIDTH-1:0] addr, input logic ovf);
    logic [ADDR_WIDTH-1:0] offset;
    offset = addr - BASE_ADDRESS;
    return !ovf && (addr >= BASE_ADDRESS) && ((offset >> SIZE_LOG2) < ADDR_WIDTH'(DEPTH));
  endfunction

  function automatic logic [MEM_AW-1:0] mem_index(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] offset;
    offset = addr - BASE_ADDRESS;
    return MEM_AW'(offset >> SIZE_LOG2);
  endfunction

  // Extra MSB is the carry out, used as the overflow flag.
  function automatic logic [ADDR_WIDTH:0] incr_addr(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr & ALIGN_MASK} + {1'b0, BEAT_BYTES};
  endfunction

  // ---------------------------------------------------------------- write
  w_state_e              w_state_reg, w_state_next;
  logic [ID_WIDTH-1:0]   aw_id_reg;
  logic [ADDR_WIDTH-1:0] w_addr_reg;
  logic                  w_ovf_reg;
  logic [7:0]            aw_len_reg;
  logic                  aw_fixed_reg;
  logic                  aw_ok_reg;
  logic [7:0]            w_cnt_reg;
  logic                  w_slverr_reg;
  logic                  w_decerr_reg;
  logic                  w_in_range;
  logic [ADDR_WIDTH:0]   w_sum;
  logic                  aw_hs, w_hs;
  logic                  mem_we;
  logic [1:0]            bresp_c;

  assign data_awready = (w_state_reg == W_IDLE) & data_aresetn;
  assign data_wready  = (w_state_reg == W_DATA) & data_aresetn;
  assign data_bvalid  = (w_state_reg == W_RESP) & data_aresetn;
  assign data_bid     = aw_id_reg;
  assign data_bresp   = bresp_c;
  assign aw_hs        = data_awvalid & data_awready;
  assign w_hs         = data_wvalid & data_wready;
  assign w_in_range   = beat_in_range(w_addr_reg, w_ovf_reg);
  assign w_sum        = incr_addr(w_addr_reg);

  always_ff @(posedge data_aclk) begin
    if (!data_aresetn) w_state_reg <= W_IDLE;
    else               w_state_reg <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state_reg;
    mem_we       = 1'b0;
    bresp_c      = RESP_OKAY;
    case (w_state_reg)
      W_IDLE: if (data_awvalid) w_state_next = W_DATA;
      W_DATA: begin
        mem_we = data_wvalid && data_aresetn && aw_ok_reg && w_in_range;
        // Burst length alone decides the end of the burst; wlast is only checked.
        if (data_wvalid && (w_cnt_reg == aw_len_reg)) w_state_next = W_RESP;
      end
      W_RESP: begin
        if (!aw_ok_reg || w_slverr_reg) bresp_c = RESP_SLVERR;
        else if (w_decerr_reg)          bresp_c = RESP_DECERR;
        if (data_bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge data_aclk) begin
    if (!data_aresetn) begin
      aw_id_reg    <= '0;
      w_addr_reg   <= '0;
      w_ovf_reg    <= 1'b0;
      aw_len_reg   <= '0;
      aw_fixed_reg <= 1'b0;
      aw_ok_reg    <= 1'b0;
      w_cnt_reg    <= '0;
      w_slverr_reg <= 1'b0;
      w_decerr_reg <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_id_reg    <= data_awid;
        w_addr_reg   <= data_awaddr;
        w_ovf_reg    <= 1'b0;
        aw_len_reg   <= data_awlen;
        aw_fixed_reg <= (data_awburst == BURST_FIXED);
        aw_ok_reg    <= supported(data_awburst, data_awsize);
        w_cnt_reg    <= '0;
        w_slverr_reg <= 1'b0;
        w_decerr_reg <= 1'b0;
      end
      if (w_hs) begin
        if (data_wlast != (w_cnt_reg == aw_len_reg)) w_slverr_reg <= 1'b1;
        if (!w_in_range)                             w_decerr_reg <= 1'b1;
        w_cnt_reg <= w_cnt_reg + 8'd1;
        if (!aw_fixed_reg) begin
          w_addr_reg <= w_sum[ADDR_WIDTH-1:0];
          w_ovf_reg  <= w_ovf_reg | w_sum[ADDR_WIDTH];
        end
      end
    end
  end

  // ----------------------------------------------------------------- read
  r_state_e              r_state_reg, r_state_next;
  logic [ID_WIDTH-1:0]   ar_id_reg;
  logic [ADDR_WIDTH-1:0] r_addr_reg;   // address of the next beat to load
  logic                  r_ovf_reg;
  logic [7:0]            ar_len_reg;
  logic                  ar_fixed_reg;
  logic                  ar_ok_reg;
  logic [7:0]            r_cnt_reg;
  logic                  r_last_reg;
  logic                  r_slverr_reg;
  logic                  r_decerr_reg;
  logic                  r_beat_ok_reg;
  logic                  ar_hs, r_hs;
  logic                  r_load;
  logic [ADDR_WIDTH-1:0] r_load_addr;
  logic                  r_load_ovf, r_load_ok, r_load_fixed, r_load_in_range;
  logic [ADDR_WIDTH:0]   r_load_sum;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign data_arready    = (r_state_reg == R_IDLE) & data_aresetn;
  assign data_rvalid     = (r_state_reg == R_DATA) & data_aresetn;
  assign data_rid        = ar_id_reg;
  assign data_rdata      = r_beat_ok_reg ? mem_rdata : '0;
  assign data_rresp      = r_slverr_reg ? RESP_SLVERR : (r_decerr_reg ? RESP_DECERR : RESP_OKAY);
  assign data_rlast      = r_last_reg & data_rvalid;
  assign ar_hs           = data_arvalid & data_arready;
  assign r_hs            = data_rvalid & data_rready;
  assign r_load_in_range = beat_in_range(r_load_addr, r_load_ovf);
  assign r_load_sum      = incr_addr(r_load_addr);

  always_ff @(posedge data_aclk) begin
    if (!data_aresetn) r_state_reg <= R_IDLE;
    else               r_state_reg <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state_reg;
    case (r_state_reg)
      R_IDLE:  if (data_arvalid) r_state_next = R_DATA;
      R_DATA:  if (data_rready && r_last_reg) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // A beat is fetched on the AR handshake and on every R handshake that is
  // not the last, so the output register only changes when it is consumed.
  always_comb begin
    r_load       = 1'b0;
    r_load_addr  = r_addr_reg;
    r_load_ovf   = r_ovf_reg;
    r_load_ok    = ar_ok_reg;
    r_load_fixed = ar_fixed_reg;
    if (ar_hs) begin
      r_load       = 1'b1;
      r_load_addr  = data_araddr;
      r_load_ovf   = 1'b0;
      r_load_ok    = supported(data_arburst, data_arsize);
      r_load_fixed = (data_arburst == BURST_FIXED);
    end else if (r_hs && !r_last_reg) begin
      r_load = 1'b1;
    end
  end

  always_ff @(posedge data_aclk) begin
    if (!data_aresetn) begin
      ar_id_reg     <= '0;
      r_addr_reg    <= '0;
      r_ovf_reg     <= 1'b0;
      ar_len_reg    <= '0;
      ar_fixed_reg  <= 1'b0;
      ar_ok_reg     <= 1'b0;
      r_cnt_reg     <= '0;
      r_last_reg    <= 1'b0;
      r_slverr_reg  <= 1'b0;
      r_decerr_reg  <= 1'b0;
      r_beat_ok_reg <= 1'b0;
    end else begin
      if (ar_hs) begin
        ar_id_reg    <= data_arid;
        ar_len_reg   <= data_arlen;
        ar_fixed_reg <= r_load_fixed;
        ar_ok_reg    <= r_load_ok;
        r_cnt_reg    <= '0;
        r_last_reg   <= (data_arlen == 8'd0);
      end else if (r_load) begin
        r_cnt_reg  <= r_cnt_reg + 8'd1;
        r_last_reg <= ((r_cnt_reg + 8'd1) == ar_len_reg);
      end
      if (r_load) begin
        r_beat_ok_reg <= r_load_ok && r_load_in_range;
        r_slverr_reg  <= !r_load_ok;
        r_decerr_reg  <= !r_load_in_range;
        if (r_load_fixed) begin
          r_addr_reg <= r_load_addr;
          r_ovf_reg  <= r_load_ovf;
        end else begin
          r_addr_reg <= r_load_sum[ADDR_WIDTH-1:0];
          r_ovf_reg  <= r_load_ovf | r_load_sum[ADDR_WIDTH];
        end
      end
    end
  end

  byte_enable_memory #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_BITS (MEM_AW)
  ) u_mem (
    .clk  (data_aclk),
    .we   (mem_we),
    .waddr(mem_index(w_addr_reg)),
    .wstrb(data_wstrb),
    .wdata(data_wdata),
    .re   (r_load),
    .raddr(mem_index(r_load_addr)),
    .rdata(mem_rdata)
  );

endmodule

// File: doc/axi_memory_responder.md
Name: axi_memory_responder

Overview:
- AXI4 subordinate backed by a byte-strobed register-array memory; the responding end of the injector's data AXI interface.
- Accepts write and read bursts and services them against internal storage.
- Instantiated next to axi_injector in testbenches and bring-up tops, so injected traffic can be read back and checked without an external memory model.

Parameters:
ID_WIDTH, 24, width of AWID/BID/ARID/RID
ADDR_WIDTH, 32, address width
DATA_WIDTH, 256, data bus width in bits; power of two, ≥ 32
DEPTH, 256, memory size in DATA_WIDTH-bit words
BASE_ADDRESS, 0, byte address of word 0; aligned to DATA_WIDTH/8

Ports:
data_aclk  in  1  clock
data_aresetn  in  1  synchronous active-low reset
data_awid/awaddr/awlen/awsize/awburst/awprot/awqos  in  ID_WIDTH/ADDR_WIDTH/8/3/2/3/4  write request
data_awvalid in 1, data_awready out 1  write request handshake
data_wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data
data_wvalid in 1, data_wready out 1  write data handshake
data_bid/bresp  out  ID_WIDTH/2  write response
data_bvalid out 1, data_bready in 1  write response handshake
data_arid/araddr/arlen/arsize/arburst/arprot/arqos  in  as AW  read request
data_arvalid in 1, data_arready out 1  read request handshake
data_rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read response
data_rvalid out 1, data_rready in 1  read response handshake

Behaviour:
- Reset
  - Clock domain: data_aclk only. Reset is synchronous and active-low (data_aresetn).
  - While data_aresetn is low: every ready/valid output is 0; bid, rid, bresp, rresp, rlast are 0; rdata is 0.
  - Reset forces both FSMs to their IDLE states. Reset mid-burst drops the burst with no response.
  - Memory contents are not reset.
- Write FSM (W_IDLE → W_DATA → W_RESP → W_IDLE)
  - W_IDLE: awready=1. On AW handshake, capture id, addr, len, burst, size.
  - W_DATA (entered the next cycle): wready=1. Each W handshake writes the strobed bytes if the beat is valid, then advances the beat address and counter.
  - After beat len+1 is accepted, go to W_RESP regardless of wlast.
  - W_RESP (next cycle after the last beat): bvalid=1, bid=captured id. Hold until bready, then go to W_IDLE. awready is high the following cycle.
- Read FSM (R_IDLE → R_DATA → R_IDLE)
  - R_IDLE: arready=1. On AR handshake, capture fields.
  - Next cycle: rvalid=1 with beat 0 registered from memory. Read-data latency is 1 cycle from AR handshake.
  - Each R handshake loads the next beat into the register. rlast=1 on beat len.
  - After the handshake on the last beat, go to R_IDLE.
  - rdata, rresp, rlast, rid hold stable while rvalid=1 and rready=0.
- Write and read channels are fully independent; one outstanding transaction per direction.
- Addressing
  - word index = (beat addr − BASE_ADDRESS) >> log2(DATA_WIDTH/8).
  - A beat is in range iff addr ≥ BASE_ADDRESS and index < DEPTH.
  - INCR: next addr = aligned addr + DATA_WIDTH/8. Address arithmetic that overflows ADDR_WIDTH makes the beat out of range.
  - FIXED: address constant for all beats.
- Unsupported requests
  - Unsupported: WRAP or reserved burst, or size ≠ log2(DATA_WIDTH/8).
  - Writes: all beats are consumed, nothing is written, bresp=SLVERR.
  - Reads: every beat returns rdata=0, rresp=SLVERR.
- Response priority
  - Writes: SLVERR (unsupported request, or a wlast mismatch on any beat) > DECERR (any beat out of range; out-of-range beats are not written) > OKAY.
  - Reads: per beat, SLVERR > DECERR (rdata=0) > OKAY.
- Same-word collision: a write beat and a read beat load in the same cycle to the same word → the read returns the old value (read-before-write).
- awprot, awqos, arprot, arqos are ignored.

Decomposition:
- Shared package axi_pkg holds:
  - burst encodings FIXED=2'b00, INCR=2'b01, WRAP=2'b10;
  - response encodings OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - write FSM and read FSM state enums.
- One sub-module, byte_enable_memory: DEPTH × DATA_WIDTH array with one byte-strobed write port and one registered read port (read-before-write).

Test Plan:
- Write INCR, addr 0x40, len 3, full strobes, data k+1 per beat k; then read the same burst → bresp OKAY, 4 read beats with data 1..4, rlast on beat 3, rvalid one cycle after AR handshake.
- Write strobe 0x0000000F over 0xFF..FF to word 2, then read word 2 → low 4 bytes updated, rest unchanged, rresp OKAY.
- Read INCR at addr (DEPTH−1)×32, len 1 → beat 0 OKAY, beat 1 rresp DECERR with rdata 0. Matching write → bresp DECERR, word DEPTH−1 written.
- WRAP write len 3 → 4 beats accepted, bresp SLVERR, memory untouched. awsize=2 read → SLVERR on every beat.
- Hold rready=0 for 5 cycles mid-burst while issuing a write to the same word → rdata stable, read shows the old value; write completes with bresp OKAY in parallel.
- Pull data_aresetn low during W_DATA beat 1 → all valid/ready outputs 0 the next cycle, no bvalid after release, next AW accepted normally.
